// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: AHB-Lite initiator turning a valid/ready command stream into single NONSEQ beats.
// Optional build macro AHB_MST_ALIGN_CHK_EN: misaligned/oversized commands complete locally with error.
`default_nettype none

module ahb_cmd_master #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 128,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              pll_core_cpuclk,
  input  logic              pad_cpu_rst_b,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_vld,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp
);

  localparam logic [1:0] c_IDLE   = 2'b00;
  localparam logic [1:0] c_NONSEQ = 2'b10;

  logic              r_ap_vld;
  logic [ADDR_W-1:0] r_ap_addr;
  logic              r_ap_write;
  logic [2:0]        r_ap_size;
  logic [DATA_W-1:0] r_ap_wdata;
  logic              r_ap_lerr;

  logic              r_dp_vld;
  logic              r_dp_write;
  logic [DATA_W-1:0] r_dp_wdata;
  logic              r_dp_lerr;

  logic              r_err2;

  logic              r_rsp_vld;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic w_cmd_lerr;
  logic w_cancel;
  logic w_ap_adv;
  logic w_dp_end;
  logic w_accept;
  logic w_hresp_err;

`ifdef AHB_MST_ALIGN_CHK_EN
  localparam logic [2:0] c_MAX_SIZE = 3'($clog2(DATA_W/8));
  logic [6:0] w_lane_mask;
  assign w_lane_mask = (7'd1 << cmd_size) - 7'd1;
  assign w_cmd_lerr  = (cmd_size > c_MAX_SIZE) | (|(cmd_addr[6:0] & w_lane_mask));
`else
  assign w_cmd_lerr  = 1'b0;
`endif

  assign w_hresp_err = (hresp != 2'b00);
  // Local-error slots never reached the bus, so hresp cannot belong to them.
  assign w_cancel    = r_dp_vld & !r_dp_lerr & !hready & w_hresp_err;
  // While the second ERROR cycle is pending the bus shows IDLE, so the address phase cannot end.
  assign w_ap_adv    = r_ap_vld & !r_err2 & hready;
  assign w_dp_end    = r_dp_vld & hready;
  assign cmd_rdy     = !r_ap_vld | w_ap_adv;
  assign w_accept    = cmd_vld & cmd_rdy;

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_ap_vld    <= 1'b0;
      r_ap_addr   <= '0;
      r_ap_write  <= 1'b0;
      r_ap_size   <= 3'b000;
      r_ap_wdata  <= '0;
      r_ap_lerr   <= 1'b0;
      r_dp_vld    <= 1'b0;
      r_dp_write  <= 1'b0;
      r_dp_wdata  <= '0;
      r_dp_lerr   <= 1'b0;
      r_err2      <= 1'b0;
      r_rsp_vld   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_ap_vld   <= 1'b1;
        r_ap_addr  <= cmd_addr;
        r_ap_write <= cmd_write;
        r_ap_size  <= cmd_size;
        r_ap_wdata <= cmd_wdata;
        r_ap_lerr  <= w_cmd_lerr;
      end else if (w_ap_adv) begin
        r_ap_vld   <= 1'b0;
      end

      if (w_ap_adv) begin
        r_dp_vld   <= 1'b1;
        r_dp_write <= r_ap_write;
        r_dp_wdata <= r_ap_wdata;
        r_dp_lerr  <= r_ap_lerr;
      end else if (w_dp_end) begin
        r_dp_vld   <= 1'b0;
      end

      r_err2    <= w_cancel;
      r_rsp_vld <= w_dp_end;
      if (w_dp_end) begin
        r_rsp_err   <= r_dp_lerr | w_hresp_err;
        r_rsp_rdata <= (!r_dp_write && !r_dp_lerr && !w_hresp_err) ? hrdata : '0;
      end
    end
  end

  assign htrans    = (r_ap_vld && !r_err2 && !r_ap_lerr) ? c_NONSEQ : c_IDLE;
  assign haddr     = r_ap_addr;
  assign hwrite    = r_ap_write;
  assign hsize     = r_ap_size;
  assign hburst    = 3'b000;
  assign hprot     = HPROT_VAL;
  assign hmastlock = 1'b0;
  assign hwdata    = r_dp_wdata;
  assign rsp_vld   = r_rsp_vld;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master: directed bench for ahb_cmd_master with a scripted AHB slave.
`default_nettype none

module tb_ahb_cmd_master;

  logic         clk;
  logic         rst_n;
  logic         cmd_vld;
  logic         cmd_rdy;
  logic [31:0]  cmd_addr;
  logic         cmd_write;
  logic [2:0]   cmd_size;
  logic [127:0] cmd_wdata;
  logic         rsp_vld;
  logic         rsp_err;
  logic [127:0] rsp_rdata;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [2:0]   hsize;
  logic [2:0]   hburst;
  logic [3:0]   hprot;
  logic         hmastlock;
  logic [127:0] hwdata;
  logic [127:0] hrdata;
  logic         hready;
  logic [1:0]   hresp;

  int checks;
  int failures;

  localparam logic [127:0] c_A5 = {16{8'hA5}};

  ahb_cmd_master dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst_b   (rst_n),
    .cmd_vld         (cmd_vld),
    .cmd_rdy         (cmd_rdy),
    .cmd_addr        (cmd_addr),
    .cmd_write       (cmd_write),
    .cmd_size        (cmd_size),
    .cmd_wdata       (cmd_wdata),
    .rsp_vld         (rsp_vld),
    .rsp_err         (rsp_err),
    .rsp_rdata       (rsp_rdata),
    .haddr           (haddr),
    .htrans          (htrans),
    .hwrite          (hwrite),
    .hsize           (hsize),
    .hburst          (hburst),
    .hprot           (hprot),
    .hmastlock       (hmastlock),
    .hwdata          (hwdata),
    .hrdata          (hrdata),
    .hready          (hready),
    .hresp           (hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [31:0] a, input logic w, input logic [2:0] s,
                         input logic [127:0] d);
    cmd_vld   = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_size  = s;
    cmd_wdata = d;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    cmd_vld   = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_size  = 3'b000;
    cmd_wdata = '0;
    hrdata    = c_A5;
    hready    = 1'b1;
    hresp     = 2'b00;

    tick();
    tick();
    chk("rst_cmd_rdy", 128'(cmd_rdy), 128'd1);
    chk("rst_htrans",  128'(htrans),  128'd0);
    chk("rst_rsp_vld", 128'(rsp_vld), 128'd0);
    chk("rst_hwdata",  hwdata,        128'd0);
    chk("rst_haddr",   128'(haddr),   128'd0);
    chk("tie_hburst",  128'(hburst),  128'd0);
    chk("tie_hprot",   128'(hprot),   128'h3);
    chk("tie_hmlock",  128'(hmastlock), 128'd0);
    rst_n = 1'b1;
    tick();

    // Single read, zero-wait slave
    set_cmd(32'h0000_1000, 1'b0, 3'b100, '0);
    #1 chk("rd_cmd_rdy", 128'(cmd_rdy), 128'd1);
    tick();
    cmd_vld = 1'b0;
    chk("rd_t1_htrans", 128'(htrans), 128'h2);
    chk("rd_t1_haddr",  128'(haddr),  128'h1000);
    chk("rd_t1_hwrite", 128'(hwrite), 128'd0);
    chk("rd_t1_hsize",  128'(hsize),  128'h4);
    tick();
    chk("rd_t2_htrans",  128'(htrans),  128'd0);
    chk("rd_t2_rsp_vld", 128'(rsp_vld), 128'd0);
    tick();
    chk("rd_t3_rsp_vld", 128'(rsp_vld), 128'd1);
    chk("rd_t3_rdata",   rsp_rdata,     c_A5);
    chk("rd_t3_err",     128'(rsp_err), 128'd0);
    tick();
    chk("rd_t4_rsp_vld", 128'(rsp_vld), 128'd0);

    // Four back-to-back writes
    for (int i = 0; i < 4; i++) begin
      set_cmd(32'(i * 16), 1'b1, 3'b100, {4{32'h1111_0000 + 32'(i)}});
      #1 chk("b2b_cmd_rdy", 128'(cmd_rdy), 128'd1);
      tick();
      chk("b2b_htrans", 128'(htrans), 128'h2);
      chk("b2b_haddr",  128'(haddr),  128'(i * 16));
      if (i >= 1) chk("b2b_hwdata", hwdata, {4{32'h1111_0000 + 32'(i - 1)}});
      chk("b2b_rsp_vld", 128'(rsp_vld), (i >= 2) ? 128'd1 : 128'd0);
    end
    cmd_vld = 1'b0;
    tick();
    chk("b2b_t5_htrans", 128'(htrans), 128'd0);
    chk("b2b_t5_hwdata", hwdata, {4{32'h1111_0003}});
    chk("b2b_t5_rsp",    128'(rsp_vld), 128'd1);
    chk("b2b_t5_rdata",  rsp_rdata, 128'd0);
    tick();
    chk("b2b_t6_rsp",    128'(rsp_vld), 128'd1);
    chk("b2b_t6_err",    128'(rsp_err), 128'd0);
    tick();
    chk("b2b_t7_rsp",    128'(rsp_vld), 128'd0);

    // Read with 3 wait states, write queued behind it
    set_cmd(32'h0000_0040, 1'b0, 3'b100, {4{32'h5A5A_0001}});
    tick();
    chk("ws_t1_htrans", 128'(htrans), 128'h2);
    set_cmd(32'h0000_0050, 1'b1, 3'b100, {4{32'hCAFE_0002}});
    tick();
    cmd_vld = 1'b0;
    hready  = 1'b0;
    hrdata  = {4{32'hBAD0_BAD0}};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ws_htrans",  128'(htrans),  128'h2);
      chk("ws_haddr",   128'(haddr),   128'h50);
      chk("ws_hwdata",  hwdata,        {4{32'h5A5A_0001}});
      chk("ws_cmd_rdy", 128'(cmd_rdy), 128'd0);
      chk("ws_rsp_vld", 128'(rsp_vld), 128'd0);
      tick();
    end
    hready = 1'b1;
    hrdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    #1 chk("ws_t5_rsp_vld", 128'(rsp_vld), 128'd0);
    tick();
    hrdata = c_A5;
    chk("ws_t6_rsp_vld", 128'(rsp_vld), 128'd1);
    chk("ws_t6_rdata",   rsp_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("ws_t6_err",     128'(rsp_err), 128'd0);
    chk("ws_t6_htrans",  128'(htrans), 128'd0);
    chk("ws_t6_hwdata",  hwdata, {4{32'hCAFE_0002}});
    tick();
    chk("ws_t7_rsp_vld", 128'(rsp_vld), 128'd1);
    chk("ws_t7_rdata",   rsp_rdata, 128'd0);
    tick();
    chk("ws_t8_rsp_vld", 128'(rsp_vld), 128'd0);

    // Two-cycle ERROR with a command pending in the address register
    set_cmd(32'h0000_0100, 1'b0, 3'b010, '0);
    tick();
    chk("er_t1_haddr", 128'(haddr), 128'h100);
    set_cmd(32'h0000_0200, 1'b1, 3'b010, {4{32'h7777_0003}});
    #1 chk("er_t1_cmd_rdy", 128'(cmd_rdy), 128'd1);
    tick();
    cmd_vld = 1'b0;
    hready  = 1'b0;
    hresp   = 2'b01;
    #1;
    chk("er_c1_htrans",  128'(htrans),  128'h2);
    chk("er_c1_haddr",   128'(haddr),   128'h200);
    chk("er_c1_cmd_rdy", 128'(cmd_rdy), 128'd0);
    tick();
    hready = 1'b1;
    #1;
    chk("er_c2_htrans",  128'(htrans),  128'd0);
    chk("er_c2_haddr",   128'(haddr),   128'h200);
    chk("er_c2_hwrite",  128'(hwrite),  128'd1);
    chk("er_c2_cmd_rdy", 128'(cmd_rdy), 128'd0);
    chk("er_c2_rsp_vld", 128'(rsp_vld), 128'd0);
    tick();
    hresp = 2'b00;
    chk("er_t4_rsp_vld", 128'(rsp_vld), 128'd1);
    chk("er_t4_err",     128'(rsp_err), 128'd1);
    chk("er_t4_rdata",   rsp_rdata,     128'd0);
    chk("er_t4_htrans",  128'(htrans),  128'h2);
    chk("er_t4_haddr",   128'(haddr),   128'h200);
    tick();
    chk("er_t5_rsp_vld", 128'(rsp_vld), 128'd0);
    chk("er_t5_htrans",  128'(htrans),  128'd0);
    chk("er_t5_hwdata",  hwdata, {4{32'h7777_0003}});
    tick();
    chk("er_t6_rsp_vld", 128'(rsp_vld), 128'd1);
    chk("er_t6_err",     128'(rsp_err), 128'd0);
    tick();

    // Reset during a data phase with one command queued
    set_cmd(32'h0000_0300, 1'b0, 3'b100, '0);
    tick();
    set_cmd(32'h0000_0310, 1'b0, 3'b100, '0);
    tick();
    cmd_vld = 1'b0;
    hready  = 1'b0;
    chk("rs_pre_htrans", 128'(htrans), 128'h2);
    rst_n = 1'b0;
    #1;
    chk("rs_htrans",  128'(htrans),  128'd0);
    chk("rs_rsp_vld", 128'(rsp_vld), 128'd0);
    chk("rs_cmd_rdy", 128'(cmd_rdy), 128'd1);
    tick();
    hready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rs_post_rsp", 128'(rsp_vld), 128'd0);
      chk("rs_post_htr", 128'(htrans),  128'd0);
    end

    // Misaligned read: addr 0x2, word size
    set_cmd(32'h0000_0002, 1'b0, 3'b010, '0);
    tick();
    cmd_vld = 1'b0;
`ifdef AHB_MST_ALIGN_CHK_EN
    chk("al_t1_htrans", 128'(htrans), 128'd0);
    tick();
    chk("al_t2_htrans", 128'(htrans), 128'd0);
    tick();
    chk("al_t3_rsp_vld", 128'(rsp_vld), 128'd1);
    chk("al_t3_err",     128'(rsp_err), 128'd1);
    chk("al_t3_rdata",   rsp_rdata,     128'd0);
`else
    chk("al_t1_htrans", 128'(htrans), 128'h2);
    chk("al_t1_haddr",  128'(haddr),  128'h2);
    tick();
    chk("al_t2_htrans", 128'(htrans), 128'd0);
    tick();
    chk("al_t3_rsp_vld", 128'(rsp_vld), 128'd1);
    chk("al_t3_err",     128'(rsp_err), 128'd0);
    chk("al_t3_rdata",   rsp_rdata,     c_A5);
`endif
    tick();
    chk("al_t4_rsp_vld", 128'(rsp_vld), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
